// File: rtl/cube_move_issuer.sv
// cube_move_issuer: sequences user moves, undos (via inverse moves) and
// LFSR-driven scrambles into a registered move command plus a one-cycle
// ischanged strobe for the 2x2 cube state controller.
module cube_move_issuer #(
  parameter int DEPTH        = 16,
  parameter int SCRAMBLE_LEN = 10,
  parameter int GAP          = 1,
  localparam int PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             req_valid,
  input  logic [4:0]       req_cmd,
  output logic             req_ready,
  input  logic             undo,
  input  logic             scramble,
  output logic [4:0]       command,
  output logic             ischanged,
  output logic             busy,
  output logic [CNT_W-1:0] hist_count,
  output logic [15:0]      move_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STROBE   = 2'd1,
    S_GAP      = 2'd2,
    S_SCR_PICK = 2'd3
  } state_t;

  state_t     state;
  logic [4:0] remaining;
  logic [3:0] prev_face;
  logic [2:0] gap_cnt;
  logic [15:0] lfsr;
  logic [PTR_W-1:0] wr_ptr;

  // Undo history storage: circular, wr_ptr points at the next free slot.
  logic [4:0] hist [DEPTH];

  logic       idle;
  logic       push_en;
  logic       req_code_ok;
  logic [4:0] top_entry;
  logic [4:0] cand;
  logic       cand_ok;
  logic       lfsr_fb;
  logic       more_scramble;

  // Request handshake, candidate qualification and history top read.
  always_comb begin
    idle          = (state == S_IDLE);
    // Scramble and undo take priority, so a request is refused while either is high.
    req_ready     = rst_n && idle && enable && !scramble && !undo;
    req_code_ok   = (req_cmd <= 5'd17);
    push_en       = req_ready && req_valid && req_code_ok;
    top_entry     = hist[wr_ptr - 1'b1];
    cand          = lfsr[4:0];
    cand_ok       = (cand <= 5'd17) && (cand[4:1] != prev_face);
    lfsr_fb       = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    more_scramble = (remaining != 5'd0) && enable;
    busy          = !idle;
  end

  // History write port; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_en) hist[wr_ptr] <= req_cmd;
  end

  // Main sequencer: decisions, counters, LFSR and the registered strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      command    <= 5'd0;
      ischanged  <= 1'b0;
      hist_count <= '0;
      move_count <= 16'd0;
      wr_ptr     <= '0;
      remaining  <= 5'd0;
      prev_face  <= 4'hF;
      gap_cnt    <= 3'd0;
      lfsr       <= 16'hACE1;
    end else begin
      lfsr      <= {lfsr_fb, lfsr[15:1]};
      ischanged <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable) begin
            if (scramble) begin
              hist_count <= '0;
              move_count <= 16'd0;
              wr_ptr     <= '0;
              remaining  <= 5'(SCRAMBLE_LEN);
              prev_face  <= 4'hF;   // no real face group uses 15
              state      <= S_SCR_PICK;
            end else if (undo) begin
              if (hist_count != '0) begin
                command    <= top_entry ^ 5'd1;
                wr_ptr     <= wr_ptr - 1'b1;
                hist_count <= hist_count - 1'b1;
                move_count <= (move_count != 16'd0) ? move_count - 16'd1 : 16'd0;
                state      <= S_STROBE;
              end
            end else if (req_valid && req_code_ok) begin
              command    <= req_cmd;
              wr_ptr     <= wr_ptr + 1'b1;
              if (hist_count != CNT_W'(DEPTH)) hist_count <= hist_count + 1'b1;
              if (move_count != 16'hFFFF) move_count <= move_count + 16'd1;
              state      <= S_STROBE;
            end
          end
        end
        S_STROBE: begin
          ischanged <= 1'b1;
          if (GAP == 0) begin
            state <= more_scramble ? S_SCR_PICK : S_IDLE;
          end else begin
            gap_cnt <= 3'(GAP);
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          // Occupies the strobe cycle plus GAP quiet cycles.
          if (gap_cnt == 3'd0) begin
            state <= more_scramble ? S_SCR_PICK : S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 3'd1;
          end
        end
        S_SCR_PICK: begin
          if (cand_ok) begin
            command   <= cand;
            prev_face <= cand[4:1];
            remaining <= remaining - 5'd1;
            state     <= S_STROBE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cube_move_issuer.sv
// Scoreboard bench for cube_move_issuer: stimulus pushes expected commands,
// a negedge monitor pops and compares on every ischanged strobe.
module tb_cube_move_issuer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       req_valid = 1'b0;
  logic [4:0] req_cmd = 5'd0;
  logic       req_ready;
  logic       undo = 1'b0;
  logic       scramble = 1'b0;
  logic [4:0] command;
  logic       ischanged;
  logic       busy;
  logic [4:0] hist_count;
  logic [15:0] move_count;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;
  bit scr_mode = 1'b0;
  logic [4:0] exp_q[$];
  logic [4:0] scr_list[$];
  logic       prev_isch = 1'b0;
  logic [4:0] prev_cmd = 5'd0;

  cube_move_issuer #(.DEPTH(16), .SCRAMBLE_LEN(10), .GAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req_valid(req_valid),
    .req_cmd(req_cmd), .req_ready(req_ready), .undo(undo), .scramble(scramble),
    .command(command), .ischanged(ischanged), .busy(busy),
    .hist_count(hist_count), .move_count(move_count)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: every strobe is compared against the scoreboard queue.
  always @(negedge clk) begin
    if (rst_n && ischanged) begin
      strobe_cnt++;
      check("strobe_width", int'(prev_isch), 0);
      check("cmd_stable", int'(command), int'(prev_cmd));
      if (scr_mode) begin
        scr_list.push_back(command);
      end else if (exp_q.size() == 0) begin
        check("unexpected_strobe", int'(command), -1);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        check("strobe_cmd", int'(command), int'(e));
        $display("strobe command=%0d expected=%0d", command, e);
      end
    end
    prev_isch = rst_n && ischanged;
    prev_cmd  = command;
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        check("idle_timeout", n, 0);
        return;
      end
    end
  endtask

  task automatic do_req(input logic [4:0] c);
    wait_idle();
    req_valid = 1'b1;
    req_cmd   = c;
    if (c <= 5'd17) exp_q.push_back(c);
    @(negedge clk);
    req_valid = 1'b0;
    $display("request cmd=%0d hist=%0d moves=%0d", c, hist_count, move_count);
  endtask

  task automatic do_undo(input bit expect_strobe, input logic [4:0] e);
    wait_idle();
    undo = 1'b1;
    if (expect_strobe) exp_q.push_back(e);
    @(negedge clk);
    undo = 1'b0;
    $display("undo hist=%0d moves=%0d", hist_count, move_count);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [4:0] codes [17];

  initial begin
    int s0;
    int n;
    // Reset values with enable already high.
    #2;
    check("rst_command", int'(command), 0);
    check("rst_ischanged", int'(ischanged), 0);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_hist", int'(hist_count), 0);
    check("rst_moves", int'(move_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Request r (0): exact latency and ready timing.
    @(negedge clk);
    req_valid = 1'b1; req_cmd = 5'd0;
    exp_q.push_back(5'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("r_isch_c0", int'(ischanged), 0);
    check("r_ready_c0", int'(req_ready), 0);
    check("r_hist", int'(hist_count), 1);
    check("r_moves", int'(move_count), 1);
    check("r_cmd", int'(command), 0);
    @(negedge clk);
    check("r_isch_c1", int'(ischanged), 1);
    check("r_ready_c1", int'(req_ready), 0);
    @(negedge clk);
    check("r_isch_c2", int'(ischanged), 0);
    check("r_ready_c2", int'(req_ready), 0);
    @(negedge clk);
    check("r_ready_c3", int'(req_ready), 1);
    $display("request r done hist=%0d moves=%0d", hist_count, move_count);

    // u, f', then three undos issue 2,5,1; fourth undo is silent.
    do_req(5'd4);
    do_req(5'd3);
    do_undo(1'b1, 5'd2);
    do_undo(1'b1, 5'd5);
    do_undo(1'b1, 5'd1);
    wait_idle();
    check("undo_hist0", int'(hist_count), 0);
    check("undo_moves0", int'(move_count), 0);
    s0 = strobe_cnt;
    do_undo(1'b0, 5'd0);
    wait_idle(); @(negedge clk);
    check("empty_undo_strobes", strobe_cnt - s0, 0);
    check("empty_undo_hist", int'(hist_count), 0);

    // Invalid code 20 is consumed; the next request is taken the following cycle.
    wait_idle();
    s0 = strobe_cnt;
    req_valid = 1'b1; req_cmd = 5'd20;
    @(negedge clk);
    check("inv_busy", int'(busy), 0);
    check("inv_hist", int'(hist_count), 0);
    check("inv_moves", int'(move_count), 0);
    req_cmd = 5'd6;
    #1 check("inv_next_ready", int'(req_ready), 1);
    exp_q.push_back(5'd6);
    @(negedge clk);
    req_valid = 1'b0;
    check("inv_next_moves", int'(move_count), 1);
    wait_idle();
    check("inv_strobes", strobe_cnt - s0, 1);
    $display("invalid request consumed, next accepted moves=%0d", move_count);

    // Fill history past DEPTH, then unwind it.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      codes[i] = 5'((i * 7 + 1) % 18);
      do_req(codes[i]);
    end
    wait_idle();
    check("full_hist", int'(hist_count), 16);
    check("full_moves", int'(move_count), 17);
    for (int i = 16; i >= 1; i--) do_undo(1'b1, codes[i] ^ 5'd1);
    wait_idle();
    check("unwind_hist", int'(hist_count), 0);
    check("unwind_moves", int'(move_count), 1);
    s0 = strobe_cnt;
    do_undo(1'b0, 5'd0);
    wait_idle(); @(negedge clk);
    check("unwind_extra_undo", strobe_cnt - s0, 0);

    // Full scramble from the reset seed.
    do_reset();
    do_req(5'd8);
    wait_idle();
    scr_mode = 1'b1;
    scr_list.delete();
    scramble = 1'b1;
    @(negedge clk);
    scramble = 1'b0;
    check("scr_clear_hist", int'(hist_count), 0);
    check("scr_clear_moves", int'(move_count), 0);
    wait_idle();
    check("scr_len", scr_list.size(), 10);
    for (int i = 0; i < scr_list.size(); i++) begin
      check("scr_code_range", int'(scr_list[i] <= 5'd17), 1);
      if (i > 0) check("scr_face_diff", int'(scr_list[i][4:1] != scr_list[i-1][4:1]), 1);
      $display("scramble move %0d code=%0d", i, scr_list[i]);
    end
    check("scr_end_hist", int'(hist_count), 0);
    check("scr_end_moves", int'(move_count), 0);
    check("scr_end_busy", int'(busy), 0);

    // Scramble with a simultaneous request; enable dropped after strobe 3.
    scr_list.delete();
    @(negedge clk);
    scramble = 1'b1; req_valid = 1'b1; req_cmd = 5'd2;
    #1 check("scr_req_ready", int'(req_ready), 0);
    @(negedge clk);
    scramble = 1'b0; req_valid = 1'b0;
    n = 0;
    s0 = 0;
    while (s0 < 3 && n < 3000) begin
      @(negedge clk);
      n++;
      if (ischanged) s0++;
    end
    check("abort_reach3", s0, 3);
    enable = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    check("abort_strobes", scr_list.size(), 3);
    check("abort_hist", int'(hist_count), 0);
    check("abort_moves", int'(move_count), 0);
    check("abort_busy", int'(busy), 0);
    scr_mode = 1'b0;
    enable = 1'b1;

    // Reset asserted during a strobe cycle.
    do_req(5'd7);
    n = 0;
    while (!ischanged && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_isch", int'(ischanged), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_isch", int'(ischanged), 0);
    check("mid_rst_cmd", int'(command), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ready", int'(req_ready), 0);
    check("mid_rst_hist", int'(hist_count), 0);
    check("mid_rst_moves", int'(move_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
